rca_config_loader: RTL and testbench
====================================

RCA_CONFIG_LOADER -- requirements
Module: rca_config_loader

Interface
REQ-001 Parameters SHALL be: NUM_RCAS (from rca_config), number of reconfigurable accelerators; NUM_READ_PORTS (from rca_config), source ports per RCA; NUM_WRITE_PORTS (from rca_config), destination ports per RCA.
REQ-002 Clock and reset SHALL be: one clock, clk, rising edge; reset is rst_n, asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration descriptor valid
- cfg_ready  out  1  descriptor accepted when cfg_valid and cfg_ready are both high
- cfg_rca_id  in  RCA_ID_W  target RCA
- cfg_src_addrs  in  5*NUM_READ_PORTS  packed source register addresses, port 0 in the LSBs
- cfg_dest_addrs  in  5*NUM_WRITE_PORTS  packed destination register addresses, port 0 in the LSBs
- cfg_src_mask  in  NUM_READ_PORTS  source port write enables
- cfg_dest_mask  in  NUM_WRITE_PORTS  destination port write enables
- rca_inflight  in  NUM_RCAS  RCA has issued, uncommitted operations
- flush  in  1  abort the current sequence
- wr_en  out  1  config-register write strobe
- rca_sel  out  RCA_ID_W  selected RCA
- w_port_sel  out  PORT_SEL_W  port index
- w_src_dest_port  out  1  0 = source, 1 = destination
- w_reg_addr  out  5  register address
- rca_busy  out  NUM_RCAS  RCA being reconfigured; the issue stage blocks issue to it
- cfg_done  out  1  one-cycle completion pulse

Function
REQ-004 FSM states SHALL be IDLE, WR_SRC, WR_DEST, SETTLE, DONE.
REQ-005 cfg_ready SHALL equal (state==IDLE) and not rca_inflight[cfg_rca_id] and not flush.
REQ-006 On accept, the descriptor SHALL be latched, the port counter cleared, and the FSM SHALL move to WR_SRC.
REQ-007 WR_SRC SHALL visit ports 0..NUM_READ_PORTS-1, one per cycle, with w_src_dest_port=0; in the last port cycle the FSM SHALL move to WR_DEST with the counter reset to 0.
REQ-008 WR_DEST SHALL visit ports 0..NUM_WRITE_PORTS-1, one per cycle, with w_src_dest_port=1; in the last port cycle the FSM SHALL move to SETTLE.
REQ-009 In WR_SRC and WR_DEST, wr_en SHALL equal the latched mask bit of the current port; w_reg_addr SHALL be that port's latched 5-bit field, and w_port_sel the counter, zero-extended to PORT_SEL_W.
REQ-010 wr_en SHALL be 0 in IDLE, SETTLE and DONE.
REQ-011 SETTLE SHALL last exactly one cycle, covering the registered read-out latency of the config registers, and SHALL then move to DONE.
REQ-012 DONE SHALL pulse cfg_done for one cycle and SHALL then return to IDLE.
REQ-013 Latency SHALL be fixed: cfg_done is high exactly NUM_READ_PORTS+NUM_WRITE_PORTS+2 cycles after the accept edge, regardless of mask contents.
REQ-014 An all-zero mask SHALL still run the full sequence with no wr_en.
REQ-015 rca_sel SHALL hold the latched id in every non-IDLE state and SHALL be 0 in IDLE.
REQ-016 rca_busy[id] SHALL be high from the cycle after accept through the cfg_done cycle inclusive; all other bits SHALL be 0.
REQ-017 A flush in any non-IDLE state SHALL force wr_en=0 in that cycle and return the FSM to IDLE next cycle; no cfg_done SHALL be issued and rca_busy SHALL clear.
REQ-018 A flush in IDLE SHALL block acceptance for that cycle (via REQ-005).
REQ-019 A new descriptor SHALL NOT be accepted in the DONE cycle; the earliest re-accept is the following IDLE cycle.

Reset
REQ-020 On rst_n low, asynchronously: state=IDLE, counter=0, latched descriptor=0, and every output 0 except cfg_ready, which then follows REQ-005.
REQ-021 A reset asserted mid-sequence SHALL discard the sequence and emit no further wr_en.

Structure
REQ-022 RCA_ID_W = $clog2(NUM_RCAS) and PORT_SEL_W = max(1, $clog2(max(NUM_READ_PORTS, NUM_WRITE_PORTS))) SHALL be defined in rca_config.
REQ-023 The loader state enum SHALL be defined in rca_config.
REQ-024 The design SHALL be a single module with no sub-modules; outputs drive the config-register write interface directly.

Verification (NUM_RCAS=4, NUM_READ_PORTS=3, NUM_WRITE_PORTS=2)
REQ-025 Full write: accept id=2, src={7,6,5}, dest={9,8}, masks all-ones -> wr_en on 5 consecutive cycles writing (src,0,5),(src,1,6),(src,2,7),(dest,0,8),(dest,1,9) with rca_sel=2, cfg_done 7 cycles after accept, rca_busy=4'b0100 throughout.
REQ-026 Partial mask: src_mask=3'b010, dest_mask=2'b00 -> single wr_en at port 1 src, cfg_done still 7 cycles after accept.
REQ-027 Inflight block: rca_inflight=4'b0010 with cfg_rca_id=1 -> cfg_ready=0; with cfg_rca_id=3 -> accepted.
REQ-028 Flush during WR_DEST port 0 -> wr_en=0 in that cycle, IDLE next cycle, no cfg_done, rca_busy=0.
REQ-029 rst_n pulsed low during WR_SRC port 1 -> outputs 0 immediately, no further wr_en; a subsequent descriptor completes normally.
REQ-030 Back-to-back: second descriptor held valid during the first sequence -> accepted in the first IDLE cycle after cfg_done, never in DONE.

Source files
------------

// File: rtl/rca_config_loader_pkg.sv
// Shared configuration for the RCA config loader: accelerator geometry,
// derived field widths and the loader FSM state encoding.
package rca_config;

  localparam int NUM_RCAS        = 4;
  localparam int NUM_READ_PORTS  = 3;
  localparam int NUM_WRITE_PORTS = 2;
  localparam int REG_ADDR_W      = 5;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int RCA_ID_W   = $clog2(NUM_RCAS);
  localparam int PORT_SEL_W = max_int(1, $clog2(max_int(NUM_READ_PORTS, NUM_WRITE_PORTS)));

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_SRC  = 3'd1,
    WR_DEST = 3'd2,
    SETTLE  = 3'd3,
    DONE    = 3'd4
  } loader_state_e;

endpackage

// File: rtl/rca_config_loader_if.sv
// Configuration descriptor handshake between the issue logic and the loader.
interface rca_config_loader_if #(
  parameter int NUM_READ_PORTS  = rca_config::NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = rca_config::NUM_WRITE_PORTS
);

  logic                                          cfg_valid;
  logic                                          cfg_ready;
  logic [rca_config::RCA_ID_W-1:0]               cfg_rca_id;
  logic [rca_config::REG_ADDR_W*NUM_READ_PORTS-1:0]  cfg_src_addrs;
  logic [rca_config::REG_ADDR_W*NUM_WRITE_PORTS-1:0] cfg_dest_addrs;
  logic [NUM_READ_PORTS-1:0]                     cfg_src_mask;
  logic [NUM_WRITE_PORTS-1:0]                    cfg_dest_mask;

  modport master (
    output cfg_valid,
    output cfg_rca_id,
    output cfg_src_addrs,
    output cfg_dest_addrs,
    output cfg_src_mask,
    output cfg_dest_mask,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_rca_id,
    input  cfg_src_addrs,
    input  cfg_dest_addrs,
    input  cfg_src_mask,
    input  cfg_dest_mask,
    output cfg_ready
  );

endinterface

// File: rtl/rca_config_loader.sv
// Walks an accepted descriptor through the source then destination port
// config registers of one RCA, holding that RCA busy until completion.
module rca_config_loader #(
  parameter int NUM_RCAS        = rca_config::NUM_RCAS,
  parameter int NUM_READ_PORTS  = rca_config::NUM_READ_PORTS,
  parameter int NUM_WRITE_PORTS = rca_config::NUM_WRITE_PORTS
) (
  input  logic                               clk,
  input  logic                               rst_n,
  rca_config_loader_if.slave                 cfg,
  input  logic [NUM_RCAS-1:0]                rca_inflight,
  input  logic                               flush,
  output logic                               wr_en,
  output logic [rca_config::RCA_ID_W-1:0]    rca_sel,
  output logic [rca_config::PORT_SEL_W-1:0]  w_port_sel,
  output logic                               w_src_dest_port,
  output logic [rca_config::REG_ADDR_W-1:0]  w_reg_addr,
  output logic [NUM_RCAS-1:0]                rca_busy,
  output logic                               cfg_done
);

  localparam int IDW = rca_config::RCA_ID_W;
  localparam int PSW = rca_config::PORT_SEL_W;
  localparam int AW  = rca_config::REG_ADDR_W;
  localparam logic [PSW-1:0] CNT_ONE   = PSW'(1'b1);
  localparam logic [PSW-1:0] LAST_SRC  = PSW'(NUM_READ_PORTS - 1);
  localparam logic [PSW-1:0] LAST_DEST = PSW'(NUM_WRITE_PORTS - 1);

  rca_config::loader_state_e state_r, state_s;
  logic [PSW-1:0]                  cnt_r, cnt_s;
  logic [IDW-1:0]                  id_r;
  logic [AW*NUM_READ_PORTS-1:0]    src_addrs_r;
  logic [AW*NUM_WRITE_PORTS-1:0]   dest_addrs_r;
  logic [NUM_READ_PORTS-1:0]       src_mask_r;
  logic [NUM_WRITE_PORTS-1:0]      dest_mask_r;

  logic            inflight_s;
  logic            ready_s;
  logic            accept_s;
  logic            active_s;
  logic [AW-1:0]   src_addr_s;
  logic [AW-1:0]   dest_addr_s;
  logic            src_en_s;
  logic            dest_en_s;

  // Inflight status of the RCA addressed by the offered descriptor.
  always_comb begin
    inflight_s = 1'b0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      inflight_s = (cfg.cfg_rca_id == IDW'(r)) ? rca_inflight[r] : inflight_s;
    end
  end

  // Acceptance handshake.
  always_comb begin
    ready_s       = (state_r == rca_config::IDLE) && !inflight_s && !flush;
    accept_s      = cfg.cfg_valid && ready_s;
    cfg.cfg_ready = ready_s;
  end

  // Select the latched address field and enable bit of the current port.
  always_comb begin
    src_addr_s  = '0;
    src_en_s    = 1'b0;
    dest_addr_s = '0;
    dest_en_s   = 1'b0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      src_addr_s = (cnt_r == PSW'(p)) ? src_addrs_r[AW*p +: AW] : src_addr_s;
      src_en_s   = (cnt_r == PSW'(p)) ? src_mask_r[p] : src_en_s;
    end
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      dest_addr_s = (cnt_r == PSW'(p)) ? dest_addrs_r[AW*p +: AW] : dest_addr_s;
      dest_en_s   = (cnt_r == PSW'(p)) ? dest_mask_r[p] : dest_en_s;
    end
  end

  // Next-state and port counter.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    if (flush && (state_r != rca_config::IDLE)) begin
      state_s = rca_config::IDLE;
      cnt_s   = '0;
    end else begin
      case (state_r)
        rca_config::IDLE: begin
          if (accept_s) begin
            state_s = rca_config::WR_SRC;
            cnt_s   = '0;
          end else begin
            state_s = rca_config::IDLE;
          end
        end
        rca_config::WR_SRC: begin
          if (cnt_r == LAST_SRC) begin
            state_s = rca_config::WR_DEST;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        rca_config::WR_DEST: begin
          if (cnt_r == LAST_DEST) begin
            state_s = rca_config::SETTLE;
            cnt_s   = '0;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        rca_config::SETTLE: state_s = rca_config::DONE;
        rca_config::DONE:   state_s = rca_config::IDLE;
        default: begin
          state_s = rca_config::IDLE;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // State and port counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= rca_config::IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Descriptor capture on accept; held for the whole sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r         <= '0;
      src_addrs_r  <= '0;
      dest_addrs_r <= '0;
      src_mask_r   <= '0;
      dest_mask_r  <= '0;
    end else if (accept_s) begin
      id_r         <= cfg.cfg_rca_id;
      src_addrs_r  <= cfg.cfg_src_addrs;
      dest_addrs_r <= cfg.cfg_dest_addrs;
      src_mask_r   <= cfg.cfg_src_mask;
      dest_mask_r  <= cfg.cfg_dest_mask;
    end
  end

  // Config-register write interface decoded from the current state.
  // A flush suppresses both the write strobe and the completion pulse.
  always_comb begin
    active_s        = (state_r != rca_config::IDLE);
    wr_en           = 1'b0;
    rca_sel         = '0;
    w_port_sel      = '0;
    w_src_dest_port = 1'b0;
    w_reg_addr      = '0;
    cfg_done        = 1'b0;
    rca_busy        = '0;
    if (active_s) begin
      rca_sel = id_r;
    end else begin
      rca_sel = '0;
    end
    for (int r = 0; r < NUM_RCAS; r++) begin
      rca_busy[r] = active_s && (id_r == IDW'(r));
    end
    case (state_r)
      rca_config::WR_SRC: begin
        wr_en           = src_en_s && !flush;
        w_port_sel      = cnt_r;
        w_src_dest_port = 1'b0;
        w_reg_addr      = src_addr_s;
      end
      rca_config::WR_DEST: begin
        wr_en           = dest_en_s && !flush;
        w_port_sel      = cnt_r;
        w_src_dest_port = 1'b1;
        w_reg_addr      = dest_addr_s;
      end
      rca_config::DONE: cfg_done = !flush;
      default: wr_en = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rca_config_loader.sv
// Randomised and directed bench for rca_config_loader against a queue-based
// model that expands each accepted descriptor into its per-cycle outputs.
module tb_rca_config_loader;

  localparam int NRCA = 4;
  localparam int NR   = 3;
  localparam int NW   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] rca_inflight = 4'b0000;
  logic       wr_en;
  logic [1:0] rca_sel;
  logic [1:0] w_port_sel;
  logic       w_src_dest_port;
  logic [4:0] w_reg_addr;
  logic [3:0] rca_busy;
  logic       cfg_done;

  always #5 clk = ~clk;

  rca_config_loader_if cfg_if ();

  rca_config_loader dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg             (cfg_if),
    .rca_inflight    (rca_inflight),
    .flush           (flush),
    .wr_en           (wr_en),
    .rca_sel         (rca_sel),
    .w_port_sel      (w_port_sel),
    .w_src_dest_port (w_src_dest_port),
    .w_reg_addr      (w_reg_addr),
    .rca_busy        (rca_busy),
    .cfg_done        (cfg_done)
  );

  typedef struct packed {
    logic       wst;
    logic       wr;
    logic       sd;
    logic [1:0] port;
    logic [4:0] addr;
    logic [1:0] sel;
    logic [3:0] busy;
    logic       done;
  } exp_t;

  exp_t q[$];
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int done_lat = -1;
  int last_acc = -1;
  int prev_acc = -1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expand an accepted descriptor into its per-cycle expected outputs.
  task automatic model_accept(input logic [1:0] id, input logic [14:0] src, input logic [9:0] dst,
                              input logic [2:0] sm, input logic [1:0] dm);
    exp_t e;
    for (int p = 0; p < NR; p++) begin
      e = '0; e.wst = 1'b1; e.wr = sm[p]; e.sd = 1'b0; e.port = 2'(p);
      e.addr = src[p*5 +: 5]; e.sel = id; e.busy = 4'b0001 << id;
      q.push_back(e);
    end
    for (int p = 0; p < NW; p++) begin
      e = '0; e.wst = 1'b1; e.wr = dm[p]; e.sd = 1'b1; e.port = 2'(p);
      e.addr = dst[p*5 +: 5]; e.sel = id; e.busy = 4'b0001 << id;
      q.push_back(e);
    end
    e = '0; e.sel = id; e.busy = 4'b0001 << id;
    q.push_back(e);
    e.done = 1'b1;
    q.push_back(e);
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input logic v, input logic [1:0] id, input logic [14:0] src, input logic [9:0] dst,
                      input logic [2:0] sm, input logic [1:0] dm, input logic [3:0] infl, input logic fl);
    exp_t e;
    logic busy_m, rdy;
    @(negedge clk);
    cfg_if.cfg_valid = v; cfg_if.cfg_rca_id = id;
    cfg_if.cfg_src_addrs = src; cfg_if.cfg_dest_addrs = dst;
    cfg_if.cfg_src_mask = sm; cfg_if.cfg_dest_mask = dm;
    rca_inflight = infl; flush = fl;
    #1;
    cyc++;
    busy_m = (q.size() != 0);
    e = busy_m ? q[0] : '0;
    rdy = !busy_m && !infl[id] && !fl;
    if (busy_m && fl) begin
      e.wr = 1'b0;
      e.done = 1'b0;
    end
    check_eq("cfg_ready", 32'(cfg_if.cfg_ready), 32'(rdy));
    check_eq("wr_en", 32'(wr_en), 32'(e.wr));
    if (e.wst) begin
      check_eq("w_port_sel", 32'(w_port_sel), 32'(e.port));
      check_eq("w_src_dest_port", 32'(w_src_dest_port), 32'(e.sd));
      check_eq("w_reg_addr", 32'(w_reg_addr), 32'(e.addr));
    end
    check_eq("rca_sel", 32'(rca_sel), 32'(e.sel));
    check_eq("rca_busy", 32'(rca_busy), 32'(e.busy));
    check_eq("cfg_done", 32'(cfg_done), 32'(e.done));
    if (wr_en) wr_cnt++;
    if (cfg_done) begin
      done_cnt++;
      done_lat = cyc - last_acc;
    end
    if (busy_m) void'(q.pop_front());
    if (busy_m && fl) q.delete();
    if (v && rdy) begin
      prev_acc = last_acc;
      last_acc = cyc;
      model_accept(id, src, dst, sm, dm);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 2'd0, 15'd0, 10'd0, 3'd0, 2'd0, 4'd0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check_eq({tag, "_cfg_done"}, 32'(cfg_done), 32'd0);
    check_eq({tag, "_rca_busy"}, 32'(rca_busy), 32'd0);
    check_eq({tag, "_rca_sel"}, 32'(rca_sel), 32'd0);
    check_eq({tag, "_w_reg_addr"}, 32'(w_reg_addr), 32'd0);
    check_eq({tag, "_w_port_sel"}, 32'(w_port_sel), 32'd0);
    check_eq({tag, "_cfg_ready"}, 32'(cfg_if.cfg_ready),
             32'(!rca_inflight[cfg_if.cfg_rca_id] && !flush));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int w0, d0;
    logic [1:0] rid;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_rca_id = 2'd0;
    cfg_if.cfg_src_addrs = 15'd0; cfg_if.cfg_dest_addrs = 10'd0;
    cfg_if.cfg_src_mask = 3'd0; cfg_if.cfg_dest_mask = 2'd0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Full write to RCA 2.
    w0 = wr_cnt;
    step(1'b1, 2'd2, {5'd7, 5'd6, 5'd5}, {5'd9, 5'd8}, 3'b111, 2'b11, 4'd0, 1'b0);
    idle(8);
    check_eq("full_wr_count", 32'(wr_cnt - w0), 32'd5);
    check_eq("full_latency", 32'(done_lat), 32'd7);

    // Partial mask: single source write.
    w0 = wr_cnt;
    step(1'b1, 2'd1, 15'($urandom), 10'($urandom), 3'b010, 2'b00, 4'd0, 1'b0);
    idle(8);
    check_eq("partial_wr_count", 32'(wr_cnt - w0), 32'd1);
    check_eq("partial_latency", 32'(done_lat), 32'd7);

    // All-zero masks still complete with fixed latency.
    w0 = wr_cnt;
    step(1'b1, 2'd0, 15'($urandom), 10'($urandom), 3'b000, 2'b00, 4'd0, 1'b0);
    idle(8);
    check_eq("zero_mask_wr_count", 32'(wr_cnt - w0), 32'd0);
    check_eq("zero_mask_latency", 32'(done_lat), 32'd7);

    // Inflight block on RCA 1, RCA 3 still accepted.
    d0 = done_cnt;
    step(1'b1, 2'd1, 15'($urandom), 10'($urandom), 3'b111, 2'b11, 4'b0010, 1'b0);
    step(1'b1, 2'd3, 15'($urandom), 10'($urandom), 3'b111, 2'b11, 4'b0010, 1'b0);
    idle(8);
    check_eq("inflight_done_count", 32'(done_cnt - d0), 32'd1);

    // Flush during WR_DEST port 0.
    d0 = done_cnt;
    step(1'b1, 2'd0, 15'($urandom), 10'($urandom), 3'b111, 2'b11, 4'd0, 1'b0);
    idle(3);
    step(1'b0, 2'd0, 15'd0, 10'd0, 3'd0, 2'd0, 4'd0, 1'b1);
    idle(8);
    check_eq("flush_no_done", 32'(done_cnt - d0), 32'd0);
    check_eq("flush_busy_clear", 32'(rca_busy), 32'd0);

    // Reset during WR_SRC port 1, then a normal descriptor.
    step(1'b1, 2'd2, 15'($urandom), 10'($urandom), 3'b111, 2'b11, 4'd0, 1'b0);
    idle(1);
    pulse_reset();
    w0 = wr_cnt;
    idle(8);
    check_eq("reset_no_wr", 32'(wr_cnt - w0), 32'd0);
    d0 = done_cnt;
    step(1'b1, 2'd2, 15'($urandom), 10'($urandom), 3'b101, 2'b10, 4'd0, 1'b0);
    idle(8);
    check_eq("post_reset_done", 32'(done_cnt - d0), 32'd1);

    // Back-to-back: descriptor held valid across a full sequence.
    d0 = done_cnt;
    repeat (16) step(1'b1, 2'd1, 15'h1234, 10'h2a5, 3'b011, 2'b01, 4'd0, 1'b0);
    idle(8);
    check_eq("b2b_accept_gap", 32'(last_acc - prev_acc), 32'd8);
    check_eq("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Randomised traffic with occasional flush, inflight and reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        pulse_reset();
      end else begin
        rid = 2'($urandom_range(0, 3));
        step(1'($urandom_range(0, 2) == 0), rid, 15'($urandom), 10'($urandom),
             3'($urandom), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0,
             1'($urandom_range(0, 24) == 0));
      end
    end
    idle(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
